// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// drives the IF/ID register. Branch/jump redirects honour one delay slot.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HELD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] hbuf_q, hbuf_d;

  logic [31:0] pc_plus4;
  logic        accept;
  logic [31:0] accept_word;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] next_pc;

  always_comb begin
    pc_plus4     = pc_q + 32'd4;
    // A word enters IF/ID either straight from memory or from the stall buffer
    accept       = ~stall & (((state_q == S_REQ) & imem_ack) | (state_q == S_HELD));
    accept_word  = (state_q == S_HELD) ? hbuf_q : imem_rdata;
    redir_valid  = ~stall & inst_valid_q & ((pcsource == 2'b01) | (pcsource == 2'b10));
    redir_target = (pcsource == 2'b01) ? bpc : jpc;
    if (redir_valid & accept) begin
      next_pc = redir_target;
    end else if (redir_pend_q) begin
      next_pc = redir_pc_q;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = imem_req_q;
    pc4_d        = pc4_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    hbuf_d       = hbuf_q;

    case (state_q)
      S_IDLE: begin
        state_d    = S_REQ;
        imem_req_d = 1'b1;
      end
      S_REQ: begin
        if (imem_ack && stall) begin
          hbuf_d     = imem_rdata;
          state_d    = S_HELD;
          imem_req_d = 1'b0;
        end else if (!imem_ack && !stall) begin
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
        end
      end
      S_HELD: begin
        if (!stall) begin
          state_d    = S_REQ;
          imem_req_d = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        imem_req_d = 1'b0;
      end
    endcase

    if (accept) begin
      pc4_d        = pc_plus4;
      inst_d       = accept_word;
      inst_valid_d = 1'b1;
      pc_d         = next_pc;
      redir_pend_d = 1'b0;
    end else if (redir_valid) begin
      // Delay slot not yet in IF/ID: remember where to go once it lands
      redir_pc_d   = redir_target;
      redir_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      pc4_q        <= 32'h0000_0000;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0000_0000;
      hbuf_q       <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      pc4_q        <= pc4_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      hbuf_q       <= hbuf_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign pc4        = pc4_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed delay-slot/stall/reset scenarios followed
// by random stall/ack/redirect traffic, all compared against a fetch model.
module tb_if_fetch_stage;

  logic        clk;
  logic        clr;
  logic        stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic        inst_valid;

  int total_checks;
  int bad_checks;

  // Reference model: what the pipeline front-end should look like
  bit          m_started;
  bit          m_held;
  logic [31:0] m_hword;
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_inst;
  bit          m_valid;
  bit          m_pend;
  logic [31:0] m_rpc;

  if_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .stall      (stall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc4        (pc4),
    .inst       (inst),
    .inst_valid (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr | 32'hA000_0000;
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_held    = 0;
    m_hword   = 32'h0;
    m_pc      = 32'h0;
    m_pc4     = 32'h0;
    m_inst    = 32'h0;
    m_valid   = 0;
    m_pend    = 0;
    m_rpc     = 32'h0;
  endtask

  // One clock of fetch behaviour, described in terms of words and redirects
  task automatic model_step(input bit st, input bit ak, input logic [1:0] ps,
                            input logic [31:0] b, input logic [31:0] j,
                            input logic [31:0] rdata);
    bit          word_ready;
    bit          redirect;
    logic [31:0] tgt;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    word_ready = m_held || ak;
    redirect   = !st && m_valid && (ps == 2'b01 || ps == 2'b10);
    tgt        = (ps == 2'b01) ? b : j;
    if (!st && word_ready) begin
      m_pc4   = m_pc + 32'd4;
      m_inst  = m_held ? m_hword : rdata;
      m_valid = 1;
      m_pc    = redirect ? tgt : (m_pend ? m_rpc : m_pc + 32'd4);
      m_pend  = 0;
      m_held  = 0;
    end else begin
      if (redirect) begin
        m_pend = 1;
        m_rpc  = tgt;
      end
      if (st && ak && !m_held) begin
        m_held  = 1;
        m_hword = rdata;
      end else if (!st && !word_ready) begin
        m_inst  = 32'h0;
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    checkOutput({tag, "_req"},   {31'b0, imem_req},   {31'b0, m_started && !m_held});
    checkOutput({tag, "_addr"},  imem_addr,           m_pc);
    checkOutput({tag, "_pc4"},   pc4,                 m_pc4);
    checkOutput({tag, "_inst"},  inst,                m_inst);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, {31'b0, m_valid});
  endtask

  // Drive one cycle of inputs, advance the model, then sample mid-low phase
  task automatic applyStimulus(input bit st, input bit ak, input logic [1:0] ps,
                               input logic [31:0] b, input logic [31:0] j,
                               input string tag);
    logic [31:0] rd;
    rd         = mem_word(m_pc);
    stall      = st;
    imem_ack   = ak;
    pcsource   = ps;
    bpc        = b;
    jpc        = j;
    imem_rdata = rd;
    model_step(st, ak, ps, b, j, rd);
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  // Asynchronous clear raised between edges while an ack is presented
  task automatic do_reset(input string tag);
    #2;
    clr        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    stall      = 1'b0;
    pcsource   = 2'b00;
    #1;
    checkOutput({tag, "_async_req"},   {31'b0, imem_req},   32'd0);
    checkOutput({tag, "_async_addr"},  imem_addr,           32'h0);
    checkOutput({tag, "_async_pc4"},   pc4,                 32'h0);
    checkOutput({tag, "_async_inst"},  inst,                32'h0);
    checkOutput({tag, "_async_valid"}, {31'b0, inst_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_held_req"},   {31'b0, imem_req},   32'd0);
    checkOutput({tag, "_held_valid"}, {31'b0, inst_valid}, 32'd0);
    clr      = 1'b0;
    imem_ack = 1'b0;
    model_reset();
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    clr          = 1'b0;
    stall        = 1'b0;
    pcsource     = 2'b00;
    bpc          = 32'h0;
    jpc          = 32'h0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // Back-to-back acks after reset release
    applyStimulus(0, 1, 2'b00, 32'h0, 32'h0, "t1a");
    checkOutput("t1_first_addr", imem_addr, 32'h0);
    applyStimulus(0, 1, 2'b00, 32'h0, 32'h0, "t1b");
    checkOutput("t1_first_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("t1_first_pc4",   pc4,  32'h4);
    checkOutput("t1_first_inst",  inst, 32'hA000_0000);
    applyStimulus(0, 1, 2'b00, 32'h0, 32'h0, "t1c");
    checkOutput("t1_addr8", imem_addr, 32'h8);

    // Ack of 0x08 under stall is buffered, then released
    applyStimulus(1, 1, 2'b00, 32'h0, 32'h0, "t2a");
    checkOutput("t2_hold_pc4", pc4, 32'h8);
    checkOutput("t2_req_low",  {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 2'b00, 32'h0, 32'h0, "t2b");
    checkOutput("t2_inst",  inst, 32'hA000_0008);
    checkOutput("t2_pc4",   pc4,  32'hC);
    checkOutput("t2_req",   {31'b0, imem_req}, 32'd1);
    checkOutput("t2_addr",  imem_addr, 32'hC);

    // Branch with same-cycle delay slot
    applyStimulus(0, 1, 2'b01, 32'h100, 32'h0, "t3a");
    checkOutput("t3_slot_inst", inst, 32'hA000_000C);
    checkOutput("t3_target",    imem_addr, 32'h100);
    applyStimulus(0, 1, 2'b00, 32'h0, 32'h0, "t3b");
    checkOutput("t3_branch_inst", inst, 32'hA000_0100);

    // Jump while memory is waiting: remembered until the slot arrives
    applyStimulus(0, 0, 2'b10, 32'h0, 32'h200, "t4a");
    checkOutput("t4_bubble", {31'b0, inst_valid}, 32'd0);
    applyStimulus(0, 0, 2'b10, 32'h0, 32'h200, "t4b");
    applyStimulus(0, 1, 2'b00, 32'h0, 32'h0, "t4c");
    checkOutput("t4_slot_inst", inst, 32'hA000_0104);
    checkOutput("t4_target",    imem_addr, 32'h200);
    applyStimulus(0, 1, 2'b00, 32'h0, 32'h0, "t4d");
    checkOutput("t4_no_extra", inst, 32'hA000_0200);

    // Reserved pcsource is sequential
    applyStimulus(0, 1, 2'b11, 32'hDEAD_BEE0, 32'hDEAD_BEE0, "t6");
    checkOutput("t6_seq_addr", imem_addr, 32'h208);

    // Clear during a wait with an ack arriving together
    applyStimulus(0, 0, 2'b00, 32'h0, 32'h0, "t5a");
    do_reset("t5");
    applyStimulus(0, 1, 2'b00, 32'h0, 32'h0, "t5b");
    checkOutput("t5_restart", imem_addr, 32'h0);
    applyStimulus(0, 1, 2'b00, 32'h0, 32'h0, "t5c");
    checkOutput("t5_inst", inst, 32'hA000_0000);

    // PC wraps from the top of the address space
    applyStimulus(0, 1, 2'b10, 32'h0, 32'hFFFF_FFFC, "wrap_a");
    checkOutput("wrap_target", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 2'b00, 32'h0, 32'h0, "wrap_b");
    checkOutput("wrap_pc4",  pc4,       32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit          st;
      bit          ak;
      logic [1:0]  ps;
      logic [31:0] b;
      logic [31:0] j;
      st = ($urandom_range(0, 3) == 0);
      ak = ($urandom_range(0, 9) < 6);
      ps = 2'($urandom_range(0, 3));
      b  = {$urandom() & 32'hFFFF_FFFC};
      j  = {$urandom() & 32'hFFFF_FFFC};
      if (i == 300) do_reset("rnd_rst");
      applyStimulus(st, ak, ps, b, j, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
